// File: rtl/npu_gemm_pkg.sv
// Shared types and defaults for the GEMM activation path: feeder FSM states,
// array geometry defaults and the int8 saturation helper.
package npu_gemm_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ARRAY_N_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_e;

  // Clamp a 9-bit signed difference into the int8 range.
  function automatic logic [7:0] sat_int8(input logic signed [8:0] x);
    if (x > 9'sd127) begin
      return 8'h7f;
    end else if (x < -9'sd128) begin
      return 8'h80;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register of {valid, data}; synchronous clear, async reset.
// DEPTH=0 is a plain wire.
module skew_delay_line
  import npu_gemm_pkg::*;
#(
  parameter int DW    = DATA_WIDTH_DEF,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, clr_i};
    assign vld_o      = vld_i;
    assign dat_o      = dat_i;
  end else begin : g_regs
    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else if (clr_i) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= vld_i;
        dat_q[0] <= dat_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/act_skew_feeder.sv
// Activation feeder: accepts vectors on a valid/ready stream and drives the array top
// edge with lane j delayed j cycles. Optional ACT_FEEDER_ZERO_POINT_EN subtracts zp.
module act_skew_feeder
  import npu_gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ARRAY_N    = ARRAY_N_DEF,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [LEN_WIDTH-1:0]          k_len,
  input  logic [DATA_WIDTH-1:0]         zp_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] in_data,
  output logic [ARRAY_N*DATA_WIDTH-1:0] out_act,
  output logic [ARRAY_N-1:0]            out_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int                   FW         = $clog2(ARRAY_N);
  localparam logic [FW-1:0]        FLUSH_LAST = FW'(ARRAY_N - 1);
  localparam logic [FW-1:0]        FLUSH_ONE  = FW'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

  feeder_state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]          klen_q, klen_d;
  logic [LEN_WIDTH-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]                 flush_q, flush_d;
  logic                          accept;
  logic                          s0_vld_q;
  logic [ARRAY_N*DATA_WIDTH-1:0] s0_dat_q;
  logic [ARRAY_N*DATA_WIDTH-1:0] lane_adj;

  assign in_ready = (state_q == STREAM);
  assign accept   = in_ready && in_valid && !abort;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          klen_d  = k_len;
          cnt_d   = '0;
          state_d = (k_len == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_ONE;
          if (cnt_q + LEN_ONE == klen_q) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = DONE;
          flush_d = '0;
        end else begin
          flush_d = flush_q + FLUSH_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // Abort outranks start, accepts and flush progress.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      flush_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      klen_q  <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

`ifdef ACT_FEEDER_ZERO_POINT_EN
  logic [DATA_WIDTH-1:0] zp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zp_q <= '0;
    end else if (state_q == IDLE && start && !abort) begin
      zp_q <= zp_in;
    end
  end

  for (genvar j = 0; j < ARRAY_N; j++) begin : g_zp
    assign lane_adj[j*DATA_WIDTH +: DATA_WIDTH] =
      sat_int8({in_data[j*DATA_WIDTH+DATA_WIDTH-1], in_data[j*DATA_WIDTH +: DATA_WIDTH]}
               - {zp_q[DATA_WIDTH-1], zp_q});
  end
`else
  logic unused_zp;
  assign unused_zp = ^zp_in;
  assign lane_adj  = in_data;
`endif

  // Stage 0 loads a bubble whenever nothing is accepted, which also covers abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      s0_dat_q <= '0;
    end else begin
      s0_vld_q <= accept;
      s0_dat_q <= accept ? lane_adj : '0;
    end
  end

  for (genvar j = 0; j < ARRAY_N; j++) begin : g_lane
    skew_delay_line #(
      .DW    (DATA_WIDTH),
      .DEPTH (j)
    ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (abort),
      .vld_i (s0_vld_q),
      .dat_i (s0_dat_q[j*DATA_WIDTH +: DATA_WIDTH]),
      .vld_o (out_valid[j]),
      .dat_o (out_act[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
